// File: rtl/oc_sched.sv
// oc_sched: round-robin scheduler sharing one ones counter (oc) between
// REQS requesters; accumulates each frame's set-bit total.
// Ports:
//   clk, rst          : clock, async active-high reset
//   req_valid/ready   : per-requester word handshake (ready one-hot or 0)
//   req_data/last     : requester r word at [r*W +: W], end of frame
//   res_valid/ready   : result handshake
//   res_count/id/ovf  : saturated frame total, requester index, saturated

module oc #(
  parameter int N = 6
) (
  input  logic [(2**(N+1))-2:0] i_data,
  output logic [N:0]            o_count
);

  always_comb begin
    o_count = '0;
    for (int i = 0; i < (2**(N+1))-1; i++)
      o_count = o_count + (N+1)'(i_data[i]);
  end

endmodule

module oc_sched #(
  parameter int N     = 6,
  parameter int REQS  = 4,
  parameter int CNT_W = 16,
  localparam int W    = (2**(N+1))-1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REQS-1:0]   req_valid,
  output logic [REQS-1:0]   req_ready,
  input  logic [REQS*W-1:0] req_data,
  input  logic [REQS-1:0]   req_last,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [CNT_W-1:0]  res_count,
  output logic [2:0]        res_id,
  output logic              res_ovf
);

  localparam int GW = (REQS > 1) ? $clog2(REQS) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_RESULT
  } state_t;

  state_t           r_state;
  logic [GW-1:0]    r_g;
  logic [GW-1:0]    r_ptr;
  logic [CNT_W-1:0] r_acc;
  logic             r_ovf;
  logic [REQS-1:0]  r_ready;
  logic             r_res_valid;
  logic [CNT_W-1:0] r_res_count;
  logic [2:0]       r_res_id;
  logic             r_res_ovf;

  logic [W-1:0]     w_word;
  logic [N:0]       w_pop;
  logic [CNT_W:0]   w_sum;
  logic [CNT_W-1:0] w_acc_nxt;
  logic             w_ovf_nxt;
  logic             w_beat;
  logic             w_hit;
  logic [GW-1:0]    w_gnt;

  always_comb begin
    w_word = req_data[int'(r_g)*W +: W];
  end

  oc #(.N(N)) u_oc (
    .i_data  (w_word),
    .o_count (w_pop)
  );

  // Carry-out of the widened sum flags saturation
  assign w_sum     = {1'b0, r_acc} + (CNT_W+1)'(w_pop);
  assign w_acc_nxt = w_sum[CNT_W] ? '1 : w_sum[CNT_W-1:0];
  assign w_ovf_nxt = r_ovf | w_sum[CNT_W];
  assign w_beat    = (r_state == S_BUSY) & req_valid[r_g];

  // First valid requester after ptr, wrapping
  always_comb begin
    w_hit = 1'b0;
    w_gnt = '0;
    for (int i = 1; i <= REQS; i++) begin
      if (!w_hit && req_valid[(int'(r_ptr)+i) % REQS]) begin
        w_hit = 1'b1;
        w_gnt = GW'((int'(r_ptr)+i) % REQS);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_g         <= '0;
      r_ptr       <= GW'(REQS-1);
      r_acc       <= '0;
      r_ovf       <= 1'b0;
      r_ready     <= '0;
      r_res_valid <= 1'b0;
      r_res_count <= '0;
      r_res_id    <= '0;
      r_res_ovf   <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (w_hit) begin
            r_g     <= w_gnt;
            r_acc   <= '0;
            r_ovf   <= 1'b0;
            r_ready <= REQS'(1) << w_gnt;
            r_state <= S_BUSY;
          end
        end
        S_BUSY: begin
          if (w_beat) begin
            r_acc <= w_acc_nxt;
            r_ovf <= w_ovf_nxt;
            if (req_last[r_g]) begin
              r_res_count <= w_acc_nxt;
              r_res_ovf   <= w_ovf_nxt;
              r_res_id    <= 3'(r_g);
              r_ptr       <= r_g;
              r_ready     <= '0;
              r_res_valid <= 1'b1;
              r_state     <= S_RESULT;
            end
          end
        end
        S_RESULT: begin
          if (res_ready) begin
            r_res_valid <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign req_ready = r_ready;
  assign res_valid = r_res_valid;
  assign res_count = r_res_count;
  assign res_id    = r_res_id;
  assign res_ovf   = r_res_ovf;

endmodule

// File: tb/tb_oc_sched.sv
// tb_oc_sched: table vectors, directed corner sequences and random rounds
// checked against a frame-level round-robin model; two accumulator widths.

module tb_oc_sched;

  localparam int W    = 127;
  localparam int R    = 4;
  localparam int MAXB = 6;

  logic           clk = 0;
  logic           rst;
  logic [R-1:0]   req_valid;
  logic [R*W-1:0] req_data;
  logic [R-1:0]   req_last;
  logic           res_ready;

  logic [R-1:0]   a_ready, b_ready;
  logic           a_valid, b_valid;
  logic [15:0]    a_count;
  logic [7:0]     b_count;
  logic [2:0]     a_id, b_id;
  logic           a_ovf, b_ovf;

  oc_sched #(.N(6), .REQS(R), .CNT_W(16)) dut_a (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(a_ready),
    .req_data(req_data), .req_last(req_last),
    .res_valid(a_valid), .res_ready(res_ready),
    .res_count(a_count), .res_id(a_id), .res_ovf(a_ovf)
  );

  oc_sched #(.N(6), .REQS(R), .CNT_W(8)) dut_b (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(b_ready),
    .req_data(req_data), .req_last(req_last),
    .res_valid(b_valid), .res_ready(res_ready),
    .res_count(b_count), .res_id(b_id), .res_ovf(b_ovf)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int mptr;

  int exp_id_q[$];
  int exp16_q[$];
  int exp8_q[$];
  bit expo16_q[$];
  bit expo8_q[$];

  logic [W-1:0] fw [R][MAXB];
  int nb [R];

  typedef struct {
    int id; int beats; int ones;
    int c16; bit o16; int c8; bit o8;
  } vec_t;
  vec_t tv [8];

  task automatic chk(input string nm, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic logic [W-1:0] mkword(input int ones, input int rot);
    logic [W-1:0] w;
    w = '0;
    for (int i = 0; i < ones; i++) w[(i+rot)%W] = 1'b1;
    return w;
  endfunction

  function automatic logic [W-1:0] rword();
    logic [127:0] t;
    t = {$urandom, $urandom, $urandom, $urandom};
    return t[W-1:0];
  endfunction

  task automatic do_reset();
    rst = 1;
    req_valid = '0;
    req_last = '0;
    res_ready = 0;
    repeat (2) @(posedge clk);
    #1 rst = 0;
    mptr = R-1;
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, "_ready"}, a_ready, 0);
    chk({nm, "_valid"}, a_valid, 0);
    chk({nm, "_count"}, a_count, 0);
    chk({nm, "_id"}, a_id, 0);
    chk({nm, "_ovf"}, a_ovf, 0);
    chk({nm, "_b_ready"}, b_ready, 0);
    chk({nm, "_b_valid"}, b_valid, 0);
    chk({nm, "_b_count"}, b_count, 0);
    chk({nm, "_b_ovf"}, b_ovf, 0);
  endtask

  task automatic drive_frame(input int id, input int beats, input int ones,
                             output logic [15:0] c16, output logic o16,
                             output logic [7:0] c8, output logic o8,
                             output logic [2:0] rid);
    int done, cyc;
    logic pr;
    done = 0; cyc = 0; pr = 0;
    req_valid[id] = 1;
    req_data[id*W +: W] = mkword(ones, 0);
    req_last[id] = (beats == 1);
    while (done < beats && cyc < 200) begin
      @(posedge clk); #1; cyc++;
      if (pr) done++;
      pr = a_ready[id];
      if (done < beats) begin
        req_data[id*W +: W] = mkword(ones, done*7);
        req_last[id] = (done == beats-1);
      end else begin
        req_valid[id] = 0;
      end
    end
    req_valid[id] = 0;
    while (!a_valid && cyc < 200) begin
      @(posedge clk); #1; cyc++;
    end
    chk("frame_timeout", cyc < 200, 1);
    c16 = a_count; o16 = a_ovf; c8 = b_count; o8 = b_ovf; rid = a_id;
    res_ready = 1;
    @(posedge clk); #1;
    res_ready = 0;
  endtask

  // Reference: results follow the masked requesters in cyclic order after
  // ptr; each total is the plain sum of popcounts, clipped to the width.
  task automatic run_round(input bit [R-1:0] mask, input bit stalls,
                           input bit bp);
    int bi [R];
    bit st [R];
    bit [R-1:0] dv;
    logic [R-1:0] rdy;
    int cyc, last, tot, r;
    bit seen;
    last = mptr;
    for (int k = 1; k <= R; k++) begin
      r = (mptr + k) % R;
      if (mask[r]) begin
        tot = 0;
        for (int b = 0; b < nb[r]; b++) tot += $countones(fw[r][b]);
        exp_id_q.push_back(r);
        exp16_q.push_back(tot > 65535 ? 65535 : tot);
        expo16_q.push_back(tot > 65535);
        exp8_q.push_back(tot > 255 ? 255 : tot);
        expo8_q.push_back(tot > 255);
        last = r;
      end
    end
    mptr = last;
    for (int i = 0; i < R; i++) begin bi[i] = 0; st[i] = 0; end
    dv = '0; rdy = '0; cyc = 0; seen = 0;
    while (exp_id_q.size() > 0 && cyc < 2000) begin
      @(posedge clk); #1; cyc++;
      for (int i = 0; i < R; i++) if (dv[i] && rdy[i]) bi[i]++;
      rdy = a_ready;
      chk("rnd_ready_w8", b_ready, a_ready);
      if (a_ready != 0) chk("rnd_grant", a_ready, 1 << exp_id_q[0]);
      for (int i = 0; i < R; i++) begin
        if (mask[i] && bi[i] < nb[i]) begin
          if (rdy[i]) st[i] = 1;
          dv[i] = st[i] && stalls ? ($urandom_range(0, 3) != 0) : 1'b1;
        end else begin
          dv[i] = 0;
        end
        req_valid[i] = dv[i];
        if (dv[i]) begin
          req_data[i*W +: W] = fw[i][bi[i]];
          req_last[i] = (bi[i] == nb[i]-1);
        end else begin
          req_data[i*W +: W] = rword();
          req_last[i] = 1'($urandom_range(0, 1));
        end
      end
      chk("rnd_valid_w8", b_valid, a_valid);
      if (a_valid) begin
        if (!seen) begin
          chk("rnd_id", a_id, exp_id_q[0]);
          chk("rnd_count", a_count, exp16_q[0]);
          chk("rnd_ovf", a_ovf, expo16_q[0]);
          chk("rnd_id_w8", b_id, exp_id_q[0]);
          chk("rnd_count_w8", b_count, exp8_q[0]);
          chk("rnd_ovf_w8", b_ovf, expo8_q[0]);
          seen = 1;
        end
        res_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
        if (res_ready) begin
          void'(exp_id_q.pop_front());
          void'(exp16_q.pop_front());
          void'(expo16_q.pop_front());
          void'(exp8_q.pop_front());
          void'(expo8_q.pop_front());
          seen = 0;
        end
      end else begin
        res_ready = 1'($urandom_range(0, 1));
      end
    end
    chk("rnd_timeout", cyc < 2000, 1);
    exp_id_q.delete(); exp16_q.delete(); expo16_q.delete();
    exp8_q.delete(); expo8_q.delete();
    @(posedge clk); #1;
    req_valid = '0;
    res_ready = 0;
  endtask

  initial begin
    logic [15:0] c16;
    logic [7:0] c8;
    logic o16, o8;
    logic [2:0] rid;
    logic [15:0] hold_c;
    logic [2:0] hold_id;
    int n, cyc;
    int f_id [5];
    int f_cnt [5];
    bit [R-1:0] mask;

    tv[0] = '{2, 1, 127, 127, 0, 127, 0};
    tv[1] = '{1, 3, 100, 300, 0, 255, 1};
    tv[2] = '{3, 2, 64, 128, 0, 128, 0};
    tv[3] = '{0, 5, 127, 635, 0, 255, 1};
    tv[4] = '{2, 1, 0, 0, 0, 0, 0};
    tv[5] = '{3, 4, 1, 4, 0, 4, 0};
    tv[6] = '{1, 3, 127, 381, 0, 255, 1};
    tv[7] = '{1, 1, 5, 5, 0, 5, 0};
    f_id  = '{0, 1, 2, 3, 0};
    f_cnt = '{1, 2, 3, 4, 1};

    rst = 1;
    req_valid = '0;
    req_last = '0;
    req_data = '0;
    res_ready = 0;
    #2;
    chk_zero("reset");
    do_reset();

    // single beat latency
    req_valid[0] = 1;
    req_data[0 +: W] = '1;
    req_last[0] = 1;
    @(posedge clk); #1;
    chk("sb_ready", a_ready, 4'b0001);
    chk("sb_early_valid", a_valid, 0);
    @(posedge clk); #1;
    req_valid[0] = 0;
    chk("sb_valid", a_valid, 1);
    chk("sb_count", a_count, 127);
    chk("sb_id", a_id, 0);
    chk("sb_ovf", a_ovf, 0);
    chk("sb_count_w8", b_count, 127);
    res_ready = 1;
    @(posedge clk); #1;
    res_ready = 0;
    chk("sb_valid_drop", a_valid, 0);

    for (int i = 0; i < 8; i++) begin
      drive_frame(tv[i].id, tv[i].beats, tv[i].ones, c16, o16, c8, o8, rid);
      chk($sformatf("tv%0d_id", i), rid, tv[i].id);
      chk($sformatf("tv%0d_count", i), c16, tv[i].c16);
      chk($sformatf("tv%0d_ovf", i), o16, tv[i].o16);
      chk($sformatf("tv%0d_count_w8", i), c8, tv[i].c8);
      chk($sformatf("tv%0d_ovf_w8", i), o8, tv[i].o8);
    end

    // multi-beat frame with two stall cycles between beats
    req_valid[2] = 1;
    req_data[2*W +: W] = mkword(127, 0);
    req_last[2] = 0;
    @(posedge clk); #1;
    chk("st_grant", a_ready, 4'b0100);
    for (int b = 0; b < 3; b++) begin
      @(posedge clk); #1;
      if (b < 2) begin
        req_valid[2] = 0;
        req_data[2*W +: W] = rword();
        req_last[2] = 1;
        repeat (2) begin
          chk("st_ready", a_ready, 4'b0100);
          @(posedge clk); #1;
        end
        chk("st_ready", a_ready, 4'b0100);
        req_valid[2] = 1;
        req_data[2*W +: W] = (b == 0) ? mkword(1, 50) : '0;
        req_last[2] = (b == 1);
      end
    end
    req_valid[2] = 0;
    chk("st_valid", a_valid, 1);
    chk("st_count", a_count, 128);
    chk("st_id", a_id, 2);
    chk("st_ready_off", a_ready, 0);
    res_ready = 1;
    @(posedge clk); #1;
    res_ready = 0;

    // result back-pressure with another requester waiting
    req_valid[3] = 1;
    req_data[3*W +: W] = mkword(9, 3);
    req_last[3] = 1;
    @(posedge clk); #1;
    chk("bp_grant3", a_ready, 4'b1000);
    req_valid[0] = 1;
    req_data[0 +: W] = mkword(6, 11);
    req_last[0] = 1;
    @(posedge clk); #1;
    req_valid[3] = 0;
    hold_c = a_count;
    hold_id = a_id;
    chk("bp_count", a_count, 9);
    chk("bp_id", a_id, 3);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("bp_valid_hold", a_valid, 1);
      chk("bp_count_hold", a_count, hold_c);
      chk("bp_id_hold", a_id, hold_id);
      chk("bp_no_grant", a_ready, 0);
    end
    res_ready = 1;
    @(posedge clk); #1;
    res_ready = 0;
    chk("bp_valid_drop", a_valid, 0);
    chk("bp_idle_ready", a_ready, 0);
    @(posedge clk); #1;
    chk("bp_next_grant", a_ready, 4'b0001);
    @(posedge clk); #1;
    req_valid[0] = 0;
    chk("bp_next_count", a_count, 6);
    chk("bp_next_id", a_id, 0);
    res_ready = 1;
    @(posedge clk); #1;
    res_ready = 0;

    // fairness with all requesters permanently valid
    do_reset();
    for (int i = 0; i < R; i++) begin
      req_data[i*W +: W] = mkword(i+1, 20*i);
      req_last[i] = 1;
    end
    req_valid = '1;
    n = 0; cyc = 0;
    while (n < 5 && cyc < 100) begin
      @(posedge clk); #1; cyc++;
      res_ready = 0;
      if (a_ready != 0) chk("fair_grant", a_ready, 1 << f_id[n]);
      if (a_valid) begin
        chk("fair_id", a_id, f_id[n]);
        chk("fair_count", a_count, f_cnt[n]);
        n++;
        res_ready = 1;
        if (n == 5) req_valid = '0;
      end
    end
    chk("fair_timeout", cyc < 100, 1);
    @(posedge clk); #1;
    res_ready = 0;

    // reset in the middle of a 4-beat frame
    do_reset();
    req_valid[1] = 1;
    req_data[1*W +: W] = mkword(40, 0);
    req_last[1] = 0;
    repeat (3) @(posedge clk);
    #1 rst = 1;
    #1;
    chk_zero("mrst");
    req_valid = '0;
    @(posedge clk); #1;
    chk("mrst_hold_valid", a_valid, 0);
    rst = 0;
    mptr = R-1;
    req_valid[1] = 1;
    req_data[1*W +: W] = mkword(7, 2);
    req_last[1] = 1;
    req_valid[3] = 1;
    req_data[3*W +: W] = mkword(3, 9);
    req_last[3] = 1;
    @(posedge clk); #1;
    chk("mrst_grant1", a_ready, 4'b0010);
    @(posedge clk); #1;
    req_valid = '0;
    chk("mrst_res_id", a_id, 1);
    chk("mrst_res_count", a_count, 7);
    res_ready = 1;
    @(posedge clk); #1;
    res_ready = 0;

    // randomized rounds against the model
    do_reset();
    for (int rnd = 0; rnd < 60; rnd++) begin
      mask = 4'($urandom_range(1, 15));
      for (int i = 0; i < R; i++) begin
        nb[i] = $urandom_range(1, MAXB);
        for (int b = 0; b < MAXB; b++) begin
          case ($urandom_range(0, 5))
            0: fw[i][b] = '1;
            1: fw[i][b] = '0;
            default: fw[i][b] = rword();
          endcase
        end
      end
      run_round(mask, rnd >= 10, rnd >= 20);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
